hil_result_packer: RTL and testbench

- Downstream sink for the generated dataflow top; consumes the 1-bit merged result stream, produced once per enabled cycle.
- Discards the pipeline fill interval, which is LATENCY enabled samples after start.
- Packs the remaining bits LSB-first into WORD_W-bit words and buffers them in a small FIFO.
- Presents the words on a valid/ready interface to the HIL host link.

---
 rtl/hil_pkg.sv | 25 ++
 rtl/hil_sync_fifo.sv | 57 +++++
 rtl/hil_result_packer.sv | 135 +++++++++++++
 tb/tb_hil_result_packer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hil_pkg.sv
// Shared types, default parameters and width helper for the HIL result packer.
package hil_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        PACK   = 2'd2
    } hil_state_e;

    localparam int HIL_WORD_W     = 8;
    localparam int HIL_LATENCY    = 33;
    localparam int HIL_FIFO_DEPTH = 4;
    localparam int HIL_CNT_W      = 16;

    // Minimum bit width able to index 'value' entries; never below one bit.
    function automatic int hil_clog2(input int value);
        int width;
        width = 1;
        while ((32'sd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/hil_sync_fifo.sv
// Small synchronous FIFO without fall-through; empty and full are told apart by an extra pointer bit.
module hil_sync_fifo
    import hil_pkg::*;
#(
    parameter int WORD_W     = HIL_WORD_W,
    parameter int FIFO_DEPTH = HIL_FIFO_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = hil_clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_r;
    logic [PTR_W:0]    rd_ptr_r;
    logic              wr_en_s;
    logic              rd_en_s;

    // A write into a full FIFO is allowed only when the head leaves in the same cycle.
    always_comb begin
        wr_en_s = push & (~full | pop);
        rd_en_s = pop & ~empty;
    end

    // Storage and pointer registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign head  = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);

endmodule

// File: rtl/hil_result_packer.sv
// Captures the merged 1-bit result stream, drops the pipeline fill samples and packs the
// remainder LSB-first into words delivered over a valid/ready link.
module hil_result_packer
    import hil_pkg::*;
#(
    parameter int WORD_W     = HIL_WORD_W,
    parameter int LATENCY    = HIL_LATENCY,
    parameter int FIFO_DEPTH = HIL_FIFO_DEPTH,
    parameter int CNT_W      = HIL_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              enable,
    input  logic              z,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [CNT_W-1:0]  word_count
);

    localparam int IDX_W  = hil_clog2(WORD_W);
    localparam int WARM_W = hil_clog2(LATENCY + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [WARM_W-1:0] WARM_ONE  = {{(WARM_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam hil_state_e        RUN_STATE = (LATENCY == 0) ? PACK : WARMUP;

    hil_state_e        state_r;
    logic [WARM_W-1:0] warm_cnt_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic [WORD_W-1:0] shift_r;
    logic              overflow_r;
    logic [CNT_W-1:0]  word_count_r;
    logic [WORD_W-1:0] word_s;
    logic              push_s;
    logic              pop_s;
    logic              empty_s;
    logic              full_s;

    // Current word including this cycle's bit, and the push/pop strobes for the buffer.
    always_comb begin
        word_s            = shift_r;
        word_s[bit_idx_r] = z;
        pop_s             = ~empty_s & out_ready;
        if (!start && !stop && (state_r == PACK) && enable && (bit_idx_r == IDX_LAST)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Run control, warm-up counting, bit packing and push bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            warm_cnt_r   <= '0;
            bit_idx_r    <= '0;
            shift_r      <= '0;
            overflow_r   <= 1'b0;
            word_count_r <= '0;
        end else if (start) begin
            state_r      <= RUN_STATE;
            warm_cnt_r   <= '0;
            bit_idx_r    <= '0;
            shift_r      <= '0;
            overflow_r   <= 1'b0;
            word_count_r <= '0;
        end else begin
            if (stop && (state_r != IDLE)) begin
                state_r   <= IDLE;
                bit_idx_r <= '0;
                shift_r   <= '0;
            end else begin
                case (state_r)
                    WARMUP: begin
                        if (enable) begin
                            if (warm_cnt_r == WARM_LAST) begin
                                state_r    <= PACK;
                                warm_cnt_r <= '0;
                            end else begin
                                warm_cnt_r <= warm_cnt_r + WARM_ONE;
                            end
                        end
                    end
                    PACK: begin
                        if (enable) begin
                            if (bit_idx_r == IDX_LAST) begin
                                bit_idx_r <= '0;
                                shift_r   <= '0;
                            end else begin
                                bit_idx_r <= bit_idx_r + IDX_ONE;
                                shift_r   <= word_s;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
            // A push into a full buffer with no pop in the same cycle loses the word.
            if (push_s) begin
                if (full_s && !pop_s) begin
                    overflow_r <= 1'b1;
                end else if (word_count_r != {CNT_W{1'b1}}) begin
                    word_count_r <= word_count_r + CNT_ONE;
                end
            end
        end
    end

    hil_sync_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (word_s),
        .pop       (pop_s),
        .head      (out_data),
        .empty     (empty_s),
        .full      (full_s)
    );

    assign out_valid  = ~empty_s;
    assign overflow   = overflow_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_hil_result_packer.sv
// Self-checking bench for hil_result_packer: vector table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_hil_result_packer;

    localparam int LAT = 33;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic        enable;
    logic        z;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [15:0] word_count;

    int checks;
    int errors;

    // Reference model state
    int        m_mode;   // 0 idle, 1 warm-up, 2 packing
    int        m_warm;
    int        m_bits;
    int        m_word;
    logic [7:0] m_q[$];
    logic       m_ovf;
    int         m_cnt;

    hil_result_packer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .enable     (enable),
        .z          (z),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_mode = 0; m_warm = 0; m_bits = 0; m_word = 0;
        m_q.delete(); m_ovf = 1'b0; m_cnt = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit   do_pop;
        bit   do_push;
        bit   was_full;
        logic [7:0] pw;
        do_pop  = (m_q.size() != 0) && out_ready;
        do_push = 1'b0;
        pw      = 8'h00;
        if (start) begin
            m_mode = (LAT == 0) ? 2 : 1;
            m_warm = 0; m_bits = 0; m_word = 0; m_ovf = 1'b0; m_cnt = 0;
        end else if (stop && m_mode != 0) begin
            m_mode = 0; m_bits = 0; m_word = 0;
        end else if (enable) begin
            if (m_mode == 1) begin
                m_warm = m_warm + 1;
                if (m_warm == LAT) m_mode = 2;
            end else if (m_mode == 2) begin
                m_word = m_word + (int'(z) << m_bits);
                m_bits = m_bits + 1;
                if (m_bits == 8) begin
                    do_push = 1'b1;
                    pw      = 8'(m_word);
                    m_bits  = 0;
                    m_word  = 0;
                end
            end
        end
        was_full = (m_q.size() == 4);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (was_full && !do_pop) begin
                m_ovf = 1'b1;
            end else begin
                m_q.push_back(pw);
                if (m_cnt != 65535) m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq({tag, ".data"}, 32'(out_data), 32'(m_q[0]));
        check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, ".count"}, 32'(word_count), 32'(m_cnt));
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic warmup(input bit zval, input bit gapped);
        for (int i = 0; i < LAT; i++) begin
            enable = 1'b1; z = zval; tick();
            if (gapped) begin
                enable = 1'b0; z = ~zval; tick();
            end
        end
        enable = 1'b0;
    endtask

    // Packs one word; out_ready is raised only during the last bit's cycle when asked.
    task automatic pack_word(input logic [7:0] w, input bit gapped, input bit ready_last);
        for (int i = 0; i < 8; i++) begin
            enable = 1'b1; z = w[i];
            if (i == 7) out_ready = ready_last;
            tick();
            if (gapped && i != 7) begin
                enable = 1'b0; z = ~w[i]; tick();
            end
        end
        enable = 1'b0; z = 1'b0; out_ready = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [7:0] z_seq;     // z_seq[i] is the i-th packed sample
        bit         warm_z;
        bit         gapped;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs[4];

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0; z = 1'b0; out_ready = 1'b0;
        model_clear();

        vecs[0] = '{"basic",  8'b0100_1101, 1'b0, 1'b0, 8'h4D};
        vecs[1] = '{"warm1",  8'b0000_0000, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{"gapped", 8'b1010_0101, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{"ones",   8'b1111_1111, 1'b0, 1'b0, 8'hFF};

        repeat (2) @(posedge clock);
        #1;
        check_eq("rst.valid", 32'(out_valid), 32'd0);
        check_eq("rst.data", 32'(out_data), 32'd0);
        check_eq("rst.overflow", 32'(overflow), 32'd0);
        check_eq("rst.count", 32'(word_count), 32'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            do_start();
            warmup(vecs[v].warm_z, vecs[v].gapped);
            check_eq({vecs[v].name, ".early"}, 32'(out_valid), 32'd0);
            pack_word(vecs[v].z_seq, vecs[v].gapped, 1'b0);
            check_eq({vecs[v].name, ".valid"}, 32'(out_valid), 32'd1);
            check_eq({vecs[v].name, ".data"}, 32'(out_data), 32'(vecs[v].exp_word));
            check_eq({vecs[v].name, ".count"}, 32'(word_count), 32'd1);
            out_ready = 1'b1; tick(); out_ready = 1'b0;
            check_eq({vecs[v].name, ".drained"}, 32'(out_valid), 32'd0);
        end

        // Backpressure: five words into a four-deep buffer
        do_start();
        warmup(1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) pack_word(8'(k), 1'b0, 1'b0);
        check_eq("bp.overflow", 32'(overflow), 32'd1);
        check_eq("bp.count", 32'(word_count), 32'd4);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("bp.order", 32'(out_data), 32'(k));
            tick();
        end
        out_ready = 1'b0;
        check_eq("bp.empty", 32'(out_valid), 32'd0);
        check_model("bp");

        // Full push with a simultaneous pop
        do_start();
        check_eq("fp.ovf_cleared", 32'(overflow), 32'd0);
        warmup(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) pack_word(8'h11 + 8'(k), 1'b0, 1'b0);
        check_eq("fp.head", 32'(out_data), 32'h11);
        pack_word(8'h15, 1'b0, 1'b1);
        check_eq("fp.overflow", 32'(overflow), 32'd0);
        check_eq("fp.count", 32'(word_count), 32'd5);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check_eq("fp.order", 32'(out_data), 32'h10 + 32'(k));
            tick();
        end
        out_ready = 1'b0;
        check_eq("fp.empty", 32'(out_valid), 32'd0);

        // Stop after three packed bits, then re-arm
        do_start();
        warmup(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1; z = 1'b1; tick();
        end
        enable = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enable = 1'b1; z = 1'b1; tick();
        end
        enable = 1'b0;
        check_eq("stop.valid", 32'(out_valid), 32'd0);
        check_eq("stop.count", 32'(word_count), 32'd0);
        do_start();
        warmup(1'b1, 1'b0);
        check_eq("rearm.early", 32'(out_valid), 32'd0);
        pack_word(8'h3C, 1'b0, 1'b0);
        check_eq("rearm.data", 32'(out_data), 32'h3C);
        check_eq("rearm.count", 32'(word_count), 32'd1);

        // Asynchronous reset in the middle of packing
        for (int k = 0; k < 4; k++) pack_word(8'h80 + 8'(k), 1'b0, 1'b0);
        check_eq("ar.pre_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1; z = 1'b1; tick();
        end
        #2 reset = 1'b1;
        #1;
        check_eq("ar.valid", 32'(out_valid), 32'd0);
        check_eq("ar.overflow", 32'(overflow), 32'd0);
        check_eq("ar.count", 32'(word_count), 32'd0);
        check_eq("ar.data", 32'(out_data), 32'd0);
        enable = 1'b0;
        model_clear();
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enable = 1'b1; z = 1'b1; tick();
        end
        check_eq("ar.idle", 32'(out_valid), 32'd0);

        // Randomized traffic against the reference model
        do_start();
        for (int c = 0; c < 4000; c++) begin
            start     = ($urandom_range(0, 299) == 0);
            stop      = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            z         = 1'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
            check_model("rand");
        end
        start = 1'b0; stop = 1'b0; enable = 1'b0; out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
